// File: rtl/intr_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter.
// Optional ack timeout is enabled by defining INTR_ARBITER_TIMEOUT_EN.
package intr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } arbState_t;

   localparam int BUSY_BIT    = 0;
   localparam int TIMEOUT_BIT = 1;

   // Index width for n sources; a single source still needs one bit.
   function automatic int idWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/intr_arbiter_prio_encoder.sv
// Fixed-priority encoder: reports the lowest set request index and a valid flag.
// Used by intr_arbiter in both builds (with or without INTR_ARBITER_TIMEOUT_EN).
module prio_encoder
   import intr_arbiter_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = idWidth(N)
) (
   input  logic [N-1:0]    req,
   output logic [ID_W-1:0] idx,
   output logic            valid
);

   // Scan high to low so the lowest set index is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intr_arbiter.sv
// Fixed-priority interrupt arbiter with MASK, ID/EOI and STATUS registers.
// Define INTR_ARBITER_TIMEOUT_EN to drop an unacknowledged interrupt after ACK_TIMEOUT cycles.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no interrupt in flight; arbitrate on eff each cycle
// ST_ASSERT  | intr high, curId latched, waiting for intr_ack
// ST_SERVICE | CPU acknowledged; waiting for EOI write to ID register
module intr_arbiter
   import intr_arbiter_pkg::*;
#(
   parameter int              BITS        = 32,
   parameter int              NUM_SRC     = 4,
   parameter logic [BITS-1:0] MASK_BASE   = BITS'(32'hF000_0100),
   parameter logic [BITS-1:0] ID_BASE     = BITS'(32'hF000_0104),
   parameter logic [BITS-1:0] STAT_BASE   = BITS'(32'hF000_0108),
   parameter int              ACK_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic               re,
   input  logic [BITS-1:0]    memAddr,
   input  logic [BITS-1:0]    dataBusIn,
   output logic [BITS-1:0]    dataBusOut,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic               intr,
   input  logic               intr_ack
);

   localparam int ID_W = idWidth(NUM_SRC);

   arbState_t          state;
   logic [NUM_SRC-1:0] mask;
   logic [ID_W-1:0]    curId;
   logic [NUM_SRC-1:0] eff;
   logic [ID_W-1:0]    winId;
   logic               winValid;
   logic               maskWr;
   logic               idWr;
   logic               statWr;
   logic               timeoutFlag;
   logic               timeoutHit;
   logic               unusedDataBits;

   assign maskWr = we && (memAddr == MASK_BASE);
   assign idWr   = we && (memAddr == ID_BASE);
   assign statWr = we && (memAddr == STAT_BASE);
   assign eff    = irq_in & mask;

   // Only the mask bits and the timeout-clear bit of the write data matter.
   assign unusedDataBits = ^dataBusIn;

   prio_encoder #(
      .N    (NUM_SRC),
      .ID_W (ID_W)
   ) uPrio (
      .req   (eff),
      .idx   (winId),
      .valid (winValid)
   );

`ifdef INTR_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(ACK_TIMEOUT);

   logic [CNT_W-1:0] ackCnt;

   assign timeoutHit = (state == ST_ASSERT) && !intr_ack
                       && (ackCnt == CNT_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ackCnt <= '0;
      end else if (state == ST_IDLE) begin
         ackCnt <= '0;
      end else if (state == ST_ASSERT && !intr_ack && !timeoutHit) begin
         ackCnt <= ackCnt + CNT_W'(1);
      end
   end

   // A new timeout wins over a same-cycle clear so the event is never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeoutFlag <= 1'b0;
      end else if (timeoutHit) begin
         timeoutFlag <= 1'b1;
      end else if (statWr && !dataBusIn[TIMEOUT_BIT]) begin
         timeoutFlag <= 1'b0;
      end
   end
`else
   localparam int unusedAckTimeout = ACK_TIMEOUT;

   assign timeoutHit  = 1'b0;
   assign timeoutFlag = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask <= '0;
      end else if (maskWr) begin
         mask <= dataBusIn[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         curId <= '0;
         intr  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (winValid) begin
                  curId <= winId;
                  state <= ST_ASSERT;
                  intr  <= 1'b1;
               end
            end
            ST_ASSERT: begin
               if (intr_ack) begin
                  state <= ST_SERVICE;
                  intr  <= 1'b0;
               end else if (timeoutHit) begin
                  state <= ST_IDLE;
                  intr  <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (idWr) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               intr  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      dataBusOut = '0;
      if (re && !we) begin
         if (memAddr == MASK_BASE) begin
            dataBusOut = BITS'(mask);
         end else if (memAddr == ID_BASE) begin
            dataBusOut = (state == ST_IDLE) ? '1 : BITS'(curId);
         end else if (memAddr == STAT_BASE) begin
            dataBusOut[BUSY_BIT]    = (state != ST_IDLE);
            dataBusOut[TIMEOUT_BIT] = timeoutFlag;
         end
      end
   end

endmodule

// File: tb/tb_intr_arbiter.sv
// Self-checking bench for intr_arbiter: directed scenarios plus randomized mask/request rounds.
// Works in both builds; the timeout scenario follows INTR_ARBITER_TIMEOUT_EN.
module tb_intr_arbiter;

   localparam logic [31:0] MASK_A = 32'hF000_0100;
   localparam logic [31:0] ID_A   = 32'hF000_0104;
   localparam logic [31:0] STAT_A = 32'hF000_0108;

   logic        clk;
   logic        reset;
   logic        we;
   logic        re;
   logic [31:0] memAddr;
   logic [31:0] dataBusIn;
   logic [31:0] dataBusOut;
   logic [3:0]  irq_in;
   logic        intr;
   logic        intr_ack;

   int compared;
   int mismatched;

   intr_arbiter #(
      .BITS        (32),
      .NUM_SRC     (4),
      .ACK_TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .re         (re),
      .memAddr    (memAddr),
      .dataBusIn  (dataBusIn),
      .dataBusOut (dataBusOut),
      .irq_in     (irq_in),
      .intr       (intr),
      .intr_ack   (intr_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
      we        = 1'b1;
      memAddr   = a;
      dataBusIn = d;
      cycle();
      we        = 1'b0;
      memAddr   = '0;
      dataBusIn = '0;
   endtask

   task automatic busRead(input logic [31:0] a, output logic [31:0] d);
      memAddr = a;
      re      = 1'b1;
      #1;
      d       = dataBusOut;
      re      = 1'b0;
      memAddr = '0;
   endtask

   task automatic pulseAck();
      intr_ack = 1'b1;
      cycle();
      intr_ack = 1'b0;
   endtask

   // Reference: lowest-index source both requesting and enabled, or -1.
   function automatic int expectedWinner(input logic [3:0] m, input logic [3:0] r);
      int eff;
      eff = int'(m & r);
      for (int i = 0; i < 4; i++)
         if (((eff >> i) & 1) == 1) return i;
      return -1;
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL reset_intr: got %0h want 0", intr); end
      busRead(MASK_A, d);
      compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL reset_mask: got %0h want 0", d); end
      busRead(ID_A, d);
      compared++; if (d !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL reset_id: got %0h want ffffffff", d); end
      busRead(STAT_A, d);
      compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL reset_status: got %0h want 0", d); end
   endtask

   task automatic test_basic();
      logic [31:0] d;
      busWrite(MASK_A, 32'hFFFF_FFF3);
      busRead(MASK_A, d);
      compared++; if (d !== 32'h3) begin mismatched++; $display("FAIL mask_readback: got %0h want 3", d); end
      irq_in = 4'b0110;
      #1;
      compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL basic_intr_early: got %0h want 0", intr); end
      cycle();
      compared++; if (intr !== 1'b1) begin mismatched++; $display("FAIL basic_intr_rise: got %0h want 1", intr); end
      busRead(ID_A, d);
      compared++; if (d !== 32'd1) begin mismatched++; $display("FAIL basic_id: got %0h want 1", d); end
      busRead(STAT_A, d);
      compared++; if (d !== 32'd1) begin mismatched++; $display("FAIL basic_status_assert: got %0h want 1", d); end
      pulseAck();
      compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL basic_intr_fall: got %0h want 0", intr); end
      busRead(STAT_A, d);
      compared++; if (d !== 32'd1) begin mismatched++; $display("FAIL basic_status_service: got %0h want 1", d); end
      irq_in = 4'b0000;
      busWrite(ID_A, $urandom);
      busRead(STAT_A, d);
      compared++; if (d !== 32'd0) begin mismatched++; $display("FAIL basic_eoi_busy: got %0h want 0", d); end
      busRead(ID_A, d);
      compared++; if (d !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL basic_id_idle: got %0h want ffffffff", d); end
   endtask

   task automatic test_ignored();
      logic [31:0] d;
      pulseAck();
      compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL idle_ack_intr: got %0h want 0", intr); end
      busRead(STAT_A, d);
      compared++; if (d !== 32'd0) begin mismatched++; $display("FAIL idle_ack_status: got %0h want 0", d); end
      busWrite(MASK_A, 32'hF);
      irq_in = 4'b1000;
      cycle();
      busWrite(ID_A, 32'h0);
      compared++; if (intr !== 1'b1) begin mismatched++; $display("FAIL assert_eoi_intr: got %0h want 1", intr); end
      busRead(STAT_A, d);
      compared++; if (d !== 32'd1) begin mismatched++; $display("FAIL assert_eoi_status: got %0h want 1", d); end
      busRead(ID_A, d);
      compared++; if (d !== 32'd3) begin mismatched++; $display("FAIL assert_eoi_id: got %0h want 3", d); end
      pulseAck();
      irq_in = 4'b0000;
      busWrite(ID_A, 32'h0);
   endtask

   task automatic test_hold();
      logic [31:0] d;
      irq_in = 4'b1100;
      cycle();
      busRead(ID_A, d);
      compared++; if (d !== 32'd2) begin mismatched++; $display("FAIL hold_id_first: got %0h want 2", d); end
      pulseAck();
      irq_in = 4'b1000;
      cycle();
      busRead(ID_A, d);
      compared++; if (d !== 32'd2) begin mismatched++; $display("FAIL hold_id_drop: got %0h want 2", d); end
      busWrite(MASK_A, 32'h0);
      busRead(ID_A, d);
      compared++; if (d !== 32'd2) begin mismatched++; $display("FAIL hold_id_masked: got %0h want 2", d); end
      irq_in = 4'b0000;
      busWrite(ID_A, 32'h0);
      busWrite(MASK_A, 32'hF);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      irq_in = 4'b0001;
      cycle();
      pulseAck();
      busWrite(ID_A, 32'h0);
      busRead(STAT_A, d);
      compared++; if (d !== 32'd0) begin mismatched++; $display("FAIL b2b_idle_busy: got %0h want 0", d); end
      compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_intr: got %0h want 0", intr); end
      cycle();
      compared++; if (intr !== 1'b1) begin mismatched++; $display("FAIL b2b_rearm_intr: got %0h want 1", intr); end
      busRead(ID_A, d);
      compared++; if (d !== 32'd0) begin mismatched++; $display("FAIL b2b_rearm_id: got %0h want 0", d); end
      pulseAck();
      irq_in = 4'b0000;
      busWrite(ID_A, 32'h0);
   endtask

   task automatic test_timeout();
      logic [31:0] d;
      irq_in = 4'b0100;
      cycle();
`ifdef INTR_ARBITER_TIMEOUT_EN
      repeat (3) cycle();
      compared++; if (intr !== 1'b1) begin mismatched++; $display("FAIL to_still_assert: got %0h want 1", intr); end
      cycle();
      irq_in = 4'b0000;
      compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL to_intr_drop: got %0h want 0", intr); end
      busRead(STAT_A, d);
      compared++; if (d !== 32'd2) begin mismatched++; $display("FAIL to_status: got %0h want 2", d); end
      busWrite(STAT_A, 32'h2);
      busRead(STAT_A, d);
      compared++; if (d !== 32'd2) begin mismatched++; $display("FAIL to_status_keep: got %0h want 2", d); end
      busWrite(STAT_A, 32'h0);
      busRead(STAT_A, d);
      compared++; if (d !== 32'd0) begin mismatched++; $display("FAIL to_status_clear: got %0h want 0", d); end
`else
      repeat (20) cycle();
      compared++; if (intr !== 1'b1) begin mismatched++; $display("FAIL nto_still_assert: got %0h want 1", intr); end
      busRead(STAT_A, d);
      compared++; if (d !== 32'd1) begin mismatched++; $display("FAIL nto_status: got %0h want 1", d); end
      pulseAck();
      irq_in = 4'b0000;
      busWrite(ID_A, 32'h0);
`endif
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [3:0]  m;
      logic [3:0]  r;
      int          w;
      for (int it = 0; it < 24; it++) begin
         m = 4'($urandom_range(0, 15));
         r = 4'($urandom_range(0, 15));
         busWrite(MASK_A, {28'($urandom), m});
         busRead(MASK_A, d);
         compared++; if (d !== {28'h0, m}) begin mismatched++; $display("FAIL rnd_mask it=%0d: got %0h want %0h", it, d, m); end
         irq_in = r;
         cycle();
         w = expectedWinner(m, r);
         compared++; if (intr !== (w >= 0)) begin mismatched++; $display("FAIL rnd_intr it=%0d: got %0h want %0h", it, intr, (w >= 0)); end
         busRead(ID_A, d);
         if (w < 0) begin
            compared++; if (d !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL rnd_id_idle it=%0d: got %0h want ffffffff", it, d); end
            irq_in = 4'b0000;
         end else begin
            compared++; if (d !== 32'(w)) begin mismatched++; $display("FAIL rnd_id it=%0d: got %0h want %0h", it, d, w); end
            pulseAck();
            irq_in = 4'($urandom_range(0, 15));
            busWrite(MASK_A, 32'($urandom));
            busRead(ID_A, d);
            compared++; if (d !== 32'(w)) begin mismatched++; $display("FAIL rnd_id_hold it=%0d: got %0h want %0h", it, d, w); end
            irq_in = 4'b0000;
            busWrite(ID_A, 32'($urandom));
            busRead(STAT_A, d);
            compared++; if (d[0] !== 1'b0) begin mismatched++; $display("FAIL rnd_eoi it=%0d: got %0h want 0", it, d[0]); end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      busWrite(MASK_A, 32'hF);
      irq_in = 4'b0001;
      cycle();
      pulseAck();
      #2;
      reset = 1'b0;
      #1;
      compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL areset_intr: got %0h want 0", intr); end
      busRead(STAT_A, d);
      compared++; if (d !== 32'd0) begin mismatched++; $display("FAIL areset_status: got %0h want 0", d); end
      busRead(MASK_A, d);
      compared++; if (d !== 32'd0) begin mismatched++; $display("FAIL areset_mask: got %0h want 0", d); end
      busRead(ID_A, d);
      compared++; if (d !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL areset_id: got %0h want ffffffff", d); end
      cycle();
      reset  = 1'b1;
      irq_in = 4'b0010;
      busWrite(MASK_A, 32'hF);
      compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL post_reset_idle: got %0h want 0", intr); end
      cycle();
      compared++; if (intr !== 1'b1) begin mismatched++; $display("FAIL post_reset_intr: got %0h want 1", intr); end
      busRead(ID_A, d);
      compared++; if (d !== 32'd1) begin mismatched++; $display("FAIL post_reset_id: got %0h want 1", d); end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      we         = 1'b0;
      re         = 1'b0;
      memAddr    = '0;
      dataBusIn  = '0;
      irq_in     = '0;
      intr_ack   = 1'b0;
      #2;
      test_reset();
      @(negedge clk);
      reset = 1'b1;
      cycle();
      test_basic();
      test_ignored();
      test_hold();
      test_back_to_back();
      test_timeout();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
